pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register that replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries an opaque data payload and a control field, adds a valid/ready handshake for stall back-pressure, and supports flush for branch or jump squash. A two-entry skid buffer keeps `in_ready` registered, so stall logic does not chain combinationally through the pipeline. On a bubble, control bits are forced to zero so downstream stages never act on a killed instruction.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_reg_if.sv | 26 ++
 rtl/pipe_entry.sv | 32 +++
 rtl/pipe_stage_reg.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register types: occupancy states, default widths and ctrl bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 8;

    // Bit positions inside the ctrl field, shared by every stage that decodes it.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_MEMTOREG = 4;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages, seen from both sides of one register.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_ready;

    // The pipeline register itself.
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    // The surrounding stages (upstream producer and downstream consumer).
    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_entry.sv
// One storage slot (valid + data + ctrl); updates on the falling clock edge.
// clr drops only the valid bit so the payload lingers; rst clears everything.
module pipe_entry #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(negedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
            ctrl <= '0;
        end else if (clr) begin
            vld  <= 1'b0;
        end else if (load) begin
            vld  <= 1'b1;
            data <= d_data;
            ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with flush and bubble masking; one-edge latency (falling edge).
// PIPE_STAGE_SKID_EN: two-entry skid with registered in_ready; otherwise single entry, in_ready = out_ready | ~out_valid.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_stage_reg_if.slave    bus
);

    logic              accept;
    logic              issue;
    logic              main_load;
    logic              main_clr;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic              main_vld;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

    assign accept = bus.in_valid & bus.in_ready;
    assign issue  = main_vld & bus.out_ready;

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .clr    (main_clr),
        .load   (main_load),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .vld    (main_vld),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

`ifdef PIPE_STAGE_SKID_EN
    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_ONE   = ONE;
    localparam logic [1:0] ST_TWO   = TWO;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              rdy_q;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clr;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (skid_clr),
        .load   (skid_load),
        .d_data (bus.in_data),
        .d_ctrl (bus.in_ctrl),
        .vld    (skid_vld),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
    );

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (issue) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so the only legal move is skid -> main.
                    if (issue) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_d_data = main_from_skid ? skid_data : bus.in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : bus.in_ctrl;

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != ST_TWO);
        end
    end

    assign bus.in_ready = rdy_q;
`else
    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
        end else if (accept) begin
            main_load = 1'b1;
        end else if (issue) begin
            main_clr = 1'b1;
        end
    end

    assign main_d_data  = bus.in_data;
    assign main_d_ctrl  = bus.in_ctrl;
    assign bus.in_ready = bus.out_ready | ~main_vld;
`endif

    assign bus.out_valid = main_vld;
    assign bus.out_data  = main_data;
    // A killed or drained slot must never present live control bits downstream.
    assign bus.out_ctrl  = main_ctrl & {CTRL_W{main_vld}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table for streaming/bubbles, hand sequences for stall, flush and reset.
// Expectations adapt to PIPE_STAGE_SKID_EN where the two builds legitimately differ.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) bus ();

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic [63:0] e_odata;
        logic [7:0]  e_octrl;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // DUT state moves on negedge; bench drives and samples just after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ctrl   = c;
        bus.out_ready = r;
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [63:0] d, input logic [7:0] c);
        chk({nm, ".out_valid"}, 64'(bus.out_valid), 64'(v));
        chk({nm, ".out_data"},  bus.out_data, d);
        chk({nm, ".out_ctrl"},  64'(bus.out_ctrl), 64'(c));
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 64'(i + 1), 8'h1F, 1'b1, 1'b1, 1'b1, 64'(i + 1), 8'h1F};
        vecs[8]  = '{1'b0, 64'h0,  8'h00, 1'b1, 1'b1, 1'b0, 64'h8,  8'h00};
        vecs[9]  = '{1'b1, 64'hAB, 8'hFF, 1'b1, 1'b1, 1'b1, 64'hAB, 8'hFF};
        vecs[10] = '{1'b0, 64'h0,  8'h00, 1'b1, 1'b1, 1'b0, 64'hAB, 8'h00};

        // Reset held across two falling edges with a live input presented.
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b1, 64'h99, 8'hFF, 1'b0);
        tick(); tick(); tick();
        chk_out("reset", 1'b0, 64'h0, 8'h00);
        chk("reset.in_ready", 64'(bus.in_ready), 64'h1);
        rst = 1'b0;
        tick();
        chk_out("post_reset_accept", 1'b1, 64'h99, 8'hFF);
        drive(1'b0, 64'h0, 8'h00, 1'b1);
        tick();
        chk_out("post_reset_drain", 1'b0, 64'h99, 8'h00);

        // Streaming and bubble masking from the table.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].vld, vecs[i].data, vecs[i].ctrl, vecs[i].ordy);
            chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_irdy));
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].e_ovld, vecs[i].e_odata, vecs[i].e_octrl);
        end

        // Stall with A, B, C offered; release and confirm order A, B, C.
        drive(1'b1, 64'hA, 8'h11, 1'b0);
        chk("stall.a.in_ready", 64'(bus.in_ready), 64'h1);
        tick();
        chk_out("stall.a", 1'b1, 64'hA, 8'h11);
        drive(1'b1, 64'hB, 8'h12, 1'b0);
        chk("stall.b.in_ready", 64'(bus.in_ready), SKID ? 64'h1 : 64'h0);
        tick();
        chk_out("stall.b", 1'b1, 64'hA, 8'h11);
        if (SKID) drive(1'b1, 64'hC, 8'h13, 1'b0);
        else      drive(1'b1, 64'hB, 8'h12, 1'b0);
        chk("stall.c.in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        chk_out("stall.c", 1'b1, 64'hA, 8'h11);
        bus.out_ready = 1'b1;
        #1;
        chk("release.in_ready", 64'(bus.in_ready), SKID ? 64'h0 : 64'h1);
        tick();
        chk_out("release.b", 1'b1, 64'hB, 8'h12);
        chk("release.in_ready_after", 64'(bus.in_ready), 64'h1);
        drive(1'b1, 64'hC, 8'h13, 1'b1);
        tick();
        chk_out("release.c", 1'b1, 64'hC, 8'h13);
        drive(1'b0, 64'h0, 8'h00, 1'b1);
        tick();
        chk_out("release.drain", 1'b0, 64'hC, 8'h00);

        // Flush while stalled full; D offered alongside the flush must be dropped.
        drive(1'b1, 64'h1A, 8'h21, 1'b0);
        tick();
        drive(1'b1, 64'h1B, 8'h22, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 64'h1D, 8'h24, 1'b0);
        tick();
        flush = 1'b0;
        chk("flush.out_valid", 64'(bus.out_valid), 64'h0);
        chk("flush.out_ctrl", 64'(bus.out_ctrl), 64'h0);
        chk("flush.in_ready", 64'(bus.in_ready), 64'h1);
        drive(1'b0, 64'h0, 8'h00, 1'b1);
        tick();
        chk("flush.no_d", 64'(bus.out_valid), 64'h0);

        // Reset while stalled full clears payload as well.
        drive(1'b1, 64'h2A, 8'h31, 1'b0);
        tick();
        drive(1'b1, 64'h2B, 8'h32, 1'b0);
        tick();
        chk_out("pre_rst_full", 1'b1, 64'h2A, 8'h31);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 64'h0, 8'h00, 1'b0);
        chk_out("rst_full", 1'b0, 64'h0, 8'h00);
        chk("rst_full.in_ready", 64'(bus.in_ready), 64'h1);
        bus.out_ready = 1'b1;
        tick();
        chk("rst_full.no_b", 64'(bus.out_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
